// File: rtl/dtp_tree_walker_if.sv
// Handshake, tree-BRAM and feature-memory signals of the decision-tree walker.
interface dtp_tree_walker_if #(
  parameter int AW = 14,
  parameter int FW = 6
);
  logic          start;
  logic [AW-1:0] root_addr;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   result;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_dout;
  logic          feat_en;
  logic [FW-1:0] feat_addr;
  logic [31:0]   feat_data;

  modport master (
    output start, root_addr, bram_dout, feat_data,
    input  busy, done, err, result, bram_en, bram_addr, feat_en, feat_addr
  );

  modport slave (
    input  start, root_addr, bram_dout, feat_data,
    output busy, done, err, result, bram_en, bram_addr, feat_en, feat_addr
  );
endinterface

// File: rtl/dtp_tree_walker.sv
// Walks a binary decision tree stored as {header, threshold} word pairs in BRAM
// and returns the class of the leaf reached, aborting after MAX_DEPTH internal nodes.
module dtp_tree_walker #(
  parameter int DTP_BRAM_AWIDTH = 14,
  parameter int FEAT_AWIDTH     = 6,
  parameter int MAX_DEPTH       = 32
) (
  input logic               clk,
  input logic               rst_n,
  dtp_tree_walker_if.slave  bus
);
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_DEPTH);

  typedef enum logic [2:0] {IDLE, RD_HDR, WT_HDR, RD_THR, CMP, FIN} state_t;

  state_t                     state_q, state_d;
  logic [DTP_BRAM_AWIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [DW-1:0]              depth_q, depth_d;
  logic [31:0]                hdr_q, hdr_d;
  logic [15:0]                result_q, result_d;
  logic                       err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      depth_q    <= '0;
      hdr_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      depth_q    <= depth_d;
      hdr_q      <= hdr_d;
      result_q   <= result_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    depth_d       = depth_q;
    hdr_d         = hdr_q;
    result_d      = result_q;
    err_d         = err_q;
    bus.bram_en   = 1'b0;
    bus.bram_addr = cur_addr_q;
    bus.feat_en   = 1'b0;
    bus.feat_addr = FEAT_AWIDTH'(hdr_q[29:24]);
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == FIN);
    bus.err       = err_q;
    bus.result    = result_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cur_addr_d = bus.root_addr;
          depth_d    = '0;
          state_d    = RD_HDR;
        end
      end
      RD_HDR: begin
        bus.bram_en = 1'b1;
        state_d     = WT_HDR;
      end
      WT_HDR: begin
        hdr_d = bus.bram_dout;
        if (bus.bram_dout[31]) begin
          result_d = bus.bram_dout[15:0];
          err_d    = 1'b0;
          state_d  = FIN;
        end else if (depth_q == DEPTH_MAX) begin
          result_d = 16'hFFFF;
          err_d    = 1'b1;
          state_d  = FIN;
        end else begin
          state_d = RD_THR;
        end
      end
      RD_THR: begin
        bus.bram_en   = 1'b1;
        bus.bram_addr = cur_addr_q + DTP_BRAM_AWIDTH'(1);
        bus.feat_en   = 1'b1;
        state_d       = CMP;
      end
      CMP: begin
        // threshold arrived in bram_dout, feature in feat_data; equality goes right
        if ($signed(bus.feat_data) < $signed(bus.bram_dout))
          cur_addr_d = cur_addr_q + DTP_BRAM_AWIDTH'(2);
        else
          cur_addr_d = DTP_BRAM_AWIDTH'(hdr_q[13:0]);
        if (depth_q != DEPTH_MAX) depth_d = depth_q + DW'(1);
        state_d = RD_HDR;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dtp_tree_walker.sv
// Directed bench for dtp_tree_walker with behavioural tree BRAM and feature memory.
module tb_dtp_tree_walker;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dtp_tree_walker_if #(.AW(14), .FW(6)) bus ();

  dtp_tree_walker #(.DTP_BRAM_AWIDTH(14), .FEAT_AWIDTH(6), .MAX_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem  [16384];
  logic [31:0] feat [64];

  always @(posedge clk) begin
    if (bus.bram_en) bus.bram_dout <= mem[bus.bram_addr];
    if (bus.feat_en) bus.feat_data <= feat[bus.feat_addr];
  end

  int n_chk = 0;
  int n_fail = 0;
  int lat, n_bram;
  logic [13:0] addrs [16];
  logic [5:0]  feat_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a walk and runs until done (bounded); optionally keeps start high with
  // a different root throughout the walk to show it is ignored while busy.
  task automatic walk(input logic [13:0] root, input bit hold_start);
    @(negedge clk);
    bus.start = 1'b1;
    bus.root_addr = root;
    @(posedge clk); #1;
    if (hold_start) bus.root_addr = 14'h0010;
    else bus.start = 1'b0;
    lat = 1; n_bram = 0; feat_seen = '1;
    while (!bus.done && lat < 100) begin
      if (bus.bram_en) begin
        if (n_bram < 16) addrs[n_bram] = bus.bram_addr;
        n_bram++;
      end
      if (bus.feat_en) feat_seen = bus.feat_addr;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    chk("done_seen", bus.done, 1'b1);
  endtask

  task automatic after_walk();
    @(posedge clk); #1;
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_done", bus.done, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    for (int i = 0; i < 64; i++) feat[i] = '0;
    bus.bram_dout = '0;
    bus.feat_data = '0;
    bus.start = 1'b0;
    bus.root_addr = '0;
    rst_n = 1'b0;

    mem[14'h0010] = 32'h8000_0005;
    mem[14'h0000] = 32'h0300_0100;
    mem[14'h0001] = 32'd10;
    mem[14'h0002] = 32'h8000_0001;
    mem[14'h0100] = 32'h8000_0002;
    mem[14'h0200] = 32'h0000_0200;
    mem[14'h0201] = 32'd0;
    feat[0] = 32'd5;

    #12;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_result", bus.result, 16'h0);
    chk("rst_bram_en", bus.bram_en, 1'b0);
    chk("rst_feat_en", bus.feat_en, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // leaf root
    walk(14'h0010, 1'b0);
    chk("leaf_lat", lat, 3);
    chk("leaf_result", bus.result, 16'h0005);
    chk("leaf_err", bus.err, 1'b0);
    chk("leaf_nbram", n_bram, 1);
    chk("leaf_addr0", addrs[0], 14'h0010);
    after_walk();

    // left branch
    feat[3] = -32'sd4;
    walk(14'h0000, 1'b0);
    chk("left_lat", lat, 7);
    chk("left_result", bus.result, 16'h0001);
    chk("left_feat_addr", feat_seen, 6'd3);
    chk("left_addr1", addrs[1], 14'h0001);
    chk("left_addr2", addrs[2], 14'h0002);
    after_walk();

    // right branch on equality
    feat[3] = 32'd10;
    walk(14'h0000, 1'b0);
    chk("right_lat", lat, 7);
    chk("right_result", bus.result, 16'h0002);
    chk("right_nbram", n_bram, 3);
    chk("right_addr0", addrs[0], 14'h0000);
    chk("right_addr1", addrs[1], 14'h0001);
    chk("right_addr2", addrs[2], 14'h0100);
    after_walk();
    repeat (3) @(posedge clk);
    #1 chk("result_held", bus.result, 16'h0002);

    // depth limit on a self-looping node
    walk(14'h0200, 1'b0);
    chk("depth_lat", lat, 11);
    chk("depth_err", bus.err, 1'b1);
    chk("depth_result", bus.result, 16'hFFFF);
    after_walk();
    chk("depth_err_held", bus.err, 1'b1);

    // wrap-around addressing, start held high while busy
    mem[14'h3FFF] = 32'h0100_0200;
    mem[14'h0000] = 32'd100;
    mem[14'h0001] = 32'h8000_0007;
    feat[1] = -32'sd1;
    walk(14'h3FFF, 1'b1);
    chk("wrap_lat", lat, 7);
    chk("wrap_result", bus.result, 16'h0007);
    chk("wrap_err", bus.err, 1'b0);
    chk("wrap_addr1", addrs[1], 14'h0000);
    chk("wrap_addr2", addrs[2], 14'h0001);
    chk("wrap_feat_addr", feat_seen, 6'd1);
    after_walk();

    // reset asserted while in CMP
    @(negedge clk);
    bus.start = 1'b1;
    bus.root_addr = 14'h0200;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("cmp_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_err", bus.err, 1'b0);
    chk("mid_rst_result", bus.result, 16'h0);
    chk("mid_rst_bram_en", bus.bram_en, 1'b0);
    chk("mid_rst_feat_en", bus.feat_en, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    walk(14'h0010, 1'b0);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_result", bus.result, 16'h0005);
    after_walk();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
